// File: rtl/axi4_video_stream_monitor_if.sv
// AXI4-Stream video bundle carrying the pixel beat plus SOF (tuser) and EOL (tlast) markers.
interface axi4_video_stream_monitor_if #(
    parameter int TDATA_WIDTH = 32
);
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic                   tuser;

    modport master (output tdata, output tvalid, input tready, output tlast, output tuser);
    modport slave  (input tdata, input tvalid, output tready, input tlast, input tuser);
endinterface

// File: rtl/axi4_video_stream_monitor.sv
// Video pass-through with a 2-entry skid buffer and a line/frame geometry checker
// that watches beats as they are accepted on the input side.
module axi4_video_stream_monitor #(
    parameter int X_TOTAL     = 2200,
    parameter int Y_TOTAL     = 1125,
    parameter int TDATA_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    axi4_video_stream_monitor_if.slave  video_i,
    axi4_video_stream_monitor_if.master video_o,
    input  logic                        clear_i,
    output logic                        locked_o,
    output logic                        line_err_o,
    output logic                        frame_err_o,
    output logic                        sticky_err_o,
    output logic [15:0]                 frame_cnt_o,
    output logic [15:0]                 err_cnt_o,
    output logic [15:0]                 last_line_len_o
);

    localparam int          BEAT_W    = TDATA_WIDTH + 2;
    localparam logic [15:0] X_TOTAL_C = 16'(X_TOTAL);
    localparam logic [15:0] Y_TOTAL_C = 16'(Y_TOTAL);

    typedef enum logic [0:0] {
        SYNC_WAIT = 1'b0,
        IN_FRAME  = 1'b1
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
    endfunction

    logic [BEAT_W-1:0] in_beat_s, out_beat_r, skid_beat_r, out_beat_n_s, skid_beat_n_s;
    logic              out_valid_r, skid_valid_r, in_ready_r;
    logic              out_valid_n_s, skid_valid_n_s, in_ready_n_s;
    logic              accept_s, deliver_s;

    state_t            state_r, state_n_s;
    logic [15:0]       px_cnt_r, ln_cnt_r, px_n_s, ln_n_s, px_plus_s;
    logic              dirty_r, dirty_n_s;
    logic              locked_r, locked_n_s;
    logic              line_err_r, frame_err_r, sticky_r, sticky_n_s;
    logic [15:0]       frame_cnt_r, frame_cnt_n_s, err_cnt_r, err_cnt_n_s;
    logic [15:0]       last_len_r, last_len_n_s;
    logic              sof_mid_s, sof_frame_s, eol_len_s, miss_eol_s;
    logic              line_err_s, frame_err_s;
    logic [2:0]        err_inc_s;
    logic [16:0]       err_sum_s;

    assign in_beat_s = {video_i.tuser, video_i.tlast, video_i.tdata};
    assign accept_s  = video_i.tvalid & in_ready_r;
    assign deliver_s = out_valid_r & video_o.tready;

    assign video_i.tready = in_ready_r;
    assign video_o.tvalid = out_valid_r;
    assign video_o.tuser  = out_beat_r[BEAT_W-1];
    assign video_o.tlast  = out_beat_r[BEAT_W-2];
    assign video_o.tdata  = out_beat_r[TDATA_WIDTH-1:0];

    assign locked_o        = locked_r;
    assign line_err_o      = line_err_r;
    assign frame_err_o     = frame_err_r;
    assign sticky_err_o    = sticky_r;
    assign frame_cnt_o     = frame_cnt_r;
    assign err_cnt_o       = err_cnt_r;
    assign last_line_len_o = last_len_r;

    // Skid buffer next state: the output register is the head entry, the skid register the tail.
    always_comb begin
        out_valid_n_s  = out_valid_r;
        out_beat_n_s   = out_beat_r;
        skid_valid_n_s = skid_valid_r;
        skid_beat_n_s  = skid_beat_r;
        if (!out_valid_r || deliver_s) begin
            if (skid_valid_r) begin
                out_valid_n_s  = 1'b1;
                out_beat_n_s   = skid_beat_r;
                skid_valid_n_s = accept_s;
                skid_beat_n_s  = accept_s ? in_beat_s : skid_beat_r;
            end else begin
                out_valid_n_s  = accept_s;
                out_beat_n_s   = accept_s ? in_beat_s : out_beat_r;
            end
        end else begin
            if (accept_s) begin
                skid_valid_n_s = 1'b1;
                skid_beat_n_s  = in_beat_s;
            end else begin
                skid_valid_n_s = skid_valid_r;
                skid_beat_n_s  = skid_beat_r;
            end
        end
        // Ready is registered from the post-update occupancy, so it never depends on video_o.tready combinationally.
        in_ready_n_s = ~(out_valid_n_s & skid_valid_n_s);
    end

    // Skid buffer storage and registered input ready.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_r  <= 1'b0;
            out_beat_r   <= '0;
            skid_valid_r <= 1'b0;
            skid_beat_r  <= '0;
            in_ready_r   <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_n_s;
            out_beat_r   <= out_beat_n_s;
            skid_valid_r <= skid_valid_n_s;
            skid_beat_r  <= skid_beat_n_s;
            in_ready_r   <= in_ready_n_s;
        end
    end

    // Monitor state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= SYNC_WAIT;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Monitor next state: leave SYNC_WAIT on the first accepted SOF and stay framed until reset.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            SYNC_WAIT: begin
                if (accept_s && video_i.tuser) begin
                    state_n_s = IN_FRAME;
                end else begin
                    state_n_s = SYNC_WAIT;
                end
            end
            IN_FRAME: state_n_s = IN_FRAME;
            default:  state_n_s = SYNC_WAIT;
        endcase
    end

    // Monitor outputs: geometry counters, error detection and lock decision for the accepted beat.
    always_comb begin
        px_n_s        = px_cnt_r;
        ln_n_s        = ln_cnt_r;
        dirty_n_s     = dirty_r;
        locked_n_s    = locked_r;
        frame_cnt_n_s = frame_cnt_r;
        last_len_n_s  = last_len_r;
        sof_mid_s     = 1'b0;
        sof_frame_s   = 1'b0;
        eol_len_s     = 1'b0;
        miss_eol_s    = 1'b0;
        px_plus_s     = sat_inc16(px_cnt_r);
        case (state_r)
            SYNC_WAIT: begin
                if (accept_s && video_i.tuser) begin
                    px_n_s    = video_i.tlast ? 16'd0 : 16'd1;
                    ln_n_s    = 16'd0;
                    dirty_n_s = 1'b0;
                end else begin
                    px_n_s    = px_cnt_r;
                end
            end
            IN_FRAME: begin
                if (accept_s && video_i.tuser) begin
                    // SOF errors belong to the frame being closed; an EOL on this beat opens the new one dirty.
                    sof_mid_s     = (px_cnt_r != 16'd0);
                    sof_frame_s   = (ln_cnt_r != Y_TOTAL_C);
                    frame_cnt_n_s = frame_cnt_r + 16'd1;
                    locked_n_s    = ~(dirty_r | sof_mid_s | sof_frame_s);
                    if (video_i.tlast) begin
                        last_len_n_s = 16'd1;
                        eol_len_s    = (X_TOTAL_C != 16'd1);
                        px_n_s       = 16'd0;
                        ln_n_s       = 16'd1;
                    end else begin
                        px_n_s       = 16'd1;
                        ln_n_s       = 16'd0;
                    end
                    dirty_n_s = eol_len_s;
                end else if (accept_s && video_i.tlast) begin
                    last_len_n_s = px_plus_s;
                    eol_len_s    = (px_plus_s != X_TOTAL_C);
                    px_n_s       = 16'd0;
                    ln_n_s       = sat_inc16(ln_cnt_r);
                    dirty_n_s    = dirty_r | eol_len_s;
                end else if (accept_s) begin
                    px_n_s       = px_plus_s;
                    miss_eol_s   = (px_plus_s == X_TOTAL_C);
                    dirty_n_s    = dirty_r | miss_eol_s;
                end else begin
                    px_n_s       = px_cnt_r;
                end
                locked_n_s = locked_n_s & ~(eol_len_s | miss_eol_s);
            end
            default: begin
                px_n_s = px_cnt_r;
            end
        endcase
        line_err_s  = sof_mid_s | eol_len_s | miss_eol_s;
        frame_err_s = sof_frame_s;
        err_inc_s   = {2'b00, sof_mid_s} + {2'b00, sof_frame_s} + {2'b00, eol_len_s} + {2'b00, miss_eol_s};
        err_sum_s   = {1'b0, err_cnt_r} + {14'd0, err_inc_s};
        err_cnt_n_s = clear_i ? 16'd0 : (err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0]);
        sticky_n_s  = clear_i ? 1'b0 : (sticky_r | line_err_s | frame_err_s);
    end

    // Monitor datapath and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            px_cnt_r    <= 16'd0;
            ln_cnt_r    <= 16'd0;
            dirty_r     <= 1'b0;
            locked_r    <= 1'b0;
            line_err_r  <= 1'b0;
            frame_err_r <= 1'b0;
            sticky_r    <= 1'b0;
            frame_cnt_r <= 16'd0;
            err_cnt_r   <= 16'd0;
            last_len_r  <= 16'd0;
        end else begin
            px_cnt_r    <= px_n_s;
            ln_cnt_r    <= ln_n_s;
            dirty_r     <= dirty_n_s;
            locked_r    <= locked_n_s;
            line_err_r  <= line_err_s;
            frame_err_r <= frame_err_s;
            sticky_r    <= sticky_n_s;
            frame_cnt_r <= frame_cnt_n_s;
            err_cnt_r   <= err_cnt_n_s;
            last_len_r  <= last_len_n_s;
        end
    end

endmodule

// File: tb/tb_axi4_video_stream_monitor.sv
// Directed and randomized bench for axi4_video_stream_monitor with an in-bench stream/geometry model.
module tb_axi4_video_stream_monitor;

    localparam int X = 8;
    localparam int Y = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        locked, line_err, frame_err, sticky;
    logic [15:0] frame_cnt, err_cnt, last_len;

    axi4_video_stream_monitor_if #(.TDATA_WIDTH(32)) vin ();
    axi4_video_stream_monitor_if #(.TDATA_WIDTH(32)) vout ();

    axi4_video_stream_monitor #(.X_TOTAL(X), .Y_TOTAL(Y), .TDATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .video_i(vin), .video_o(vout), .clear_i(clear_i),
        .locked_o(locked), .line_err_o(line_err), .frame_err_o(frame_err), .sticky_err_o(sticky),
        .frame_cnt_o(frame_cnt), .err_cnt_o(err_cnt), .last_line_len_o(last_len)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0, n_total = 0, n_fail = 0;
    int low_pct = 0;
    int cyc = 0;
    bit last_acc;
    logic [33:0] q[$];

    // Reference model state (plain integers, spec rules).
    bit m_sync, m_dirty, m_locked, m_lp, m_fp, m_sticky;
    int m_px, m_ln, m_fcnt, m_ecnt, m_last;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sync = 0; m_dirty = 0; m_locked = 0; m_lp = 0; m_fp = 0; m_sticky = 0;
        m_px = 0; m_ln = 0; m_fcnt = 0; m_ecnt = 0; m_last = 0;
        q.delete();
    endtask

    task automatic model_step(input bit acc, input bit u, input bit l, input bit clr);
        int errs, eol_errs, len;
        errs = 0; eol_errs = 0; m_lp = 0; m_fp = 0;
        if (acc && !m_sync) begin
            if (u) begin
                m_sync = 1; m_px = l ? 0 : 1; m_ln = 0; m_dirty = 0;
            end
        end else if (acc) begin
            len = imin(m_px + 1, 65535);
            if (u) begin
                if (m_px != 0) begin m_lp = 1; errs++; end
                if (m_ln != Y) begin m_fp = 1; errs++; end
                m_fcnt = (m_fcnt + 1) % 65536;
                m_locked = (!m_dirty && errs == 0);
                m_dirty = 0; m_ln = 0; len = 1;
            end
            if (l) begin
                m_last = len;
                if (len != X) begin m_lp = 1; eol_errs++; end
                m_px = 0; m_ln = imin(m_ln + 1, 65535);
            end else begin
                m_px = len;
                if (len == X) begin m_lp = 1; eol_errs++; end
            end
            errs += eol_errs;
            if (eol_errs != 0) m_dirty = 1;
            if (errs != 0) m_locked = 0;
        end
        m_ecnt   = clr ? 0 : imin(m_ecnt + errs, 65535);
        m_sticky = clr ? 1'b0 : (m_sticky | (errs != 0));
    endtask

    // One clock: check at the falling edge, advance model, then return just after the rising edge.
    task automatic tick();
        bit acc, dlv;
        @(negedge clk_i);
        check("in_tready", vin.tready, (q.size() < 2));
        check("out_tvalid", vout.tvalid, (q.size() != 0));
        if (q.size() != 0 && vout.tvalid === 1'b1)
            check("out_beat", {vout.tuser, vout.tlast, vout.tdata}, q[0]);
        check("locked", locked, m_locked);
        check("line_err", line_err, m_lp);
        check("frame_err", frame_err, m_fp);
        check("sticky", sticky, m_sticky);
        check("frame_cnt", frame_cnt, m_fcnt);
        check("err_cnt", err_cnt, m_ecnt);
        check("last_len", last_len, m_last);
        acc = vin.tvalid & vin.tready;
        dlv = vout.tvalid & vout.tready;
        if (dlv && q.size() != 0) void'(q.pop_front());
        if (acc) q.push_back({vin.tuser, vin.tlast, vin.tdata});
        model_step(acc, vin.tuser, vin.tlast, clear_i);
        last_acc = acc;
        cyc++;
        @(posedge clk_i);
        #1;
        vout.tready = ($urandom_range(0, 99) >= low_pct);
    endtask

    task automatic send(input bit u, input bit l);
        bit done;
        done = 0;
        vin.tvalid = 1'b1; vin.tdata = $urandom; vin.tuser = u; vin.tlast = l;
        for (int k = 0; k < 200 && !done; k++) begin
            tick();
            done = last_acc;
        end
        if (!done) check("accept_timeout", done, 1'b1);
        vin.tvalid = 1'b0;
    endtask

    task automatic send_line(input int n, input bit sof);
        for (int i = 0; i < n; i++) send(sof && i == 0, i == n - 1);
    endtask

    task automatic send_frame(input int lines, input int len);
        for (int j = 0; j < lines; j++) send_line(len, j == 0);
    endtask

    task automatic idle(input int n);
        vin.tvalid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        vin.tvalid = 1'b0;
        for (int k = 0; k < 200 && q.size() != 0; k++) tick();
        check("drain", q.size(), 0);
        idle(2);
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; vin.tvalid = 1'b0; clear_i = 1'b0;
        #2;
        check("rst_out_tvalid", vout.tvalid, 64'd0);
        check("rst_out_tdata", vout.tdata, 64'd0);
        check("rst_out_tlast", vout.tlast, 64'd0);
        check("rst_out_tuser", vout.tuser, 64'd0);
        check("rst_in_tready", vin.tready, 64'd0);
        check("rst_locked", locked, 64'd0);
        check("rst_line_err", line_err, 64'd0);
        check("rst_frame_err", frame_err, 64'd0);
        check("rst_sticky", sticky, 64'd0);
        check("rst_frame_cnt", frame_cnt, 64'd0);
        check("rst_err_cnt", err_cnt, 64'd0);
        check("rst_last_len", last_len, 64'd0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int c0, gpos, gline;
        bit u, l;
        vin.tvalid = 1'b0; vin.tdata = '0; vin.tuser = 1'b0; vin.tlast = 1'b0;
        vout.tready = 1'b1;
        #1;
        do_reset();

        // Beats before any SOF, including EOLs, are ignored.
        send_line(5, 0); send_line(3, 0); send_line(1, 0);
        idle(2);
        check("presync_frame_cnt", frame_cnt, 64'd0);
        check("presync_locked", locked, 64'd0);
        check("presync_err_cnt", err_cnt, 64'd0);

        // Sync frame plus three clean frames at full rate.
        send_frame(Y, X);
        c0 = cyc;
        send_frame(Y, X);
        check("throughput_cycles", cyc - c0, X * Y);
        send_frame(Y, X);
        send_frame(Y, X);
        idle(2);
        check("clean_frame_cnt", frame_cnt, 64'd3);
        check("clean_locked", locked, 64'd1);
        check("clean_err_cnt", err_cnt, 64'd0);

        // Short line (6 beats), then recovery on the next clean frame.
        send_line(X, 1); send_line(6, 0);
        idle(2);
        check("short_last_len", last_len, 64'd6);
        check("short_err_cnt", err_cnt, 64'd1);
        check("short_sticky", sticky, 64'd1);
        check("short_locked", locked, 64'd0);
        send_line(X, 0); send_line(X, 0);
        send_frame(Y, X);
        send_frame(Y, X);
        idle(2);
        check("relock", locked, 64'd1);

        // Three-line frame, then SOF mid-line at px_cnt=3.
        pulse_clear();
        send_frame(3, X);
        send_line(X, 1);
        idle(2);
        check("short_frame_err_cnt", err_cnt, 64'd1);
        send_line(X, 0); send_line(X, 0);
        send(0, 0); send(0, 0); send(0, 0);
        send_line(X, 1);
        idle(2);
        check("midline_sof_err_cnt", err_cnt, 64'd3);

        // Randomized stream with ~30% output back-pressure and occasional marker faults.
        low_pct = 30; gpos = 0; gline = 0;
        for (int i = 0; i < 1000; i++) begin
            u = (gpos == 0 && gline == 0);
            l = (gpos == X - 1);
            if ($urandom_range(0, 99) < 3) u = ~u;
            if ($urandom_range(0, 99) < 3) l = ~l;
            if ($urandom_range(0, 9) == 0) idle(1);
            send(u, l);
            if (l) begin gpos = 0; gline = (gline + 1) % Y; end
            else gpos++;
        end
        drain();
        low_pct = 0;

        // Fill the buffer under full back-pressure, then reset mid-frame.
        send(1, 0); send(0, 0);
        low_pct = 100;
        vin.tvalid = 1'b1; vin.tuser = 1'b0; vin.tlast = 1'b0;
        for (int k = 0; k < 10 && q.size() < 2; k++) begin
            vin.tdata = $urandom;
            tick();
        end
        check("buffer_full", q.size(), 2);
        do_reset();
        low_pct = 0;
        send_line(4, 0);
        send_line(X, 1);
        for (int k = 0; k < 5; k++) send_line(3, 0);
        idle(2);
        check("five_err_cnt", err_cnt, 64'd5);
        check("five_sticky", sticky, 64'd1);
        check("post_reset_frame_cnt", frame_cnt, 64'd0);
        pulse_clear();
        idle(1);
        check("clear_err_cnt", err_cnt, 64'd0);
        check("clear_sticky", sticky, 64'd0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
